// File: rtl/gpu_axis_pkg.sv
// Shared types and constants for the AXI-Stream heap ingest path.
//   state_t : writer FSM states
//   LANE_W  : width of one heap word / stream lane
//   clog2   : index width helper, never returns less than 1 so a
//             single-lane build still has a usable lane index
package gpu_axis_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN,
        DONE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/axis_heap_writer_if.sv
// AXI-Stream beat bus feeding the heap writer.
//   axis_tdata  : LANES x 32-bit words, lane 0 in the low bits
//   axis_tkeep  : one bit per lane, 0 = lane skipped
//   axis_tlast  : last beat of frame
//   axis_tvalid : beat valid (master)
//   axis_tready : beat accept (slave)
interface axis_heap_writer_if #(
    parameter int LANES = 2
);
    logic [gpu_axis_pkg::LANE_W*LANES-1:0] axis_tdata;
    logic [LANES-1:0]                      axis_tkeep;
    logic                                  axis_tlast;
    logic                                  axis_tvalid;
    logic                                  axis_tready;

    modport master (
        output axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
        input  axis_tready
    );

    modport slave (
        input  axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
        output axis_tready
    );
endinterface

// File: rtl/axis_lane_unpacker.sv
// Holds one accepted beat and walks it lane by lane.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : accept a new beat (in_*) into the buffer, lane index -> 0
//   advance     : step the lane index by one
//   discard     : drop the buffered beat
//   issue_word  : word to register onto the heap port at this edge;
//                 lane 0 of in_data while loading, else the lane after
//                 the current one
//   issue_keep  : keep bit matching issue_word
//   last_lane   : current lane is the final lane of the beat
//   buf_last    : buffered beat carried tlast
module axis_lane_unpacker
    import gpu_axis_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    advance,
    input  logic                    discard,
    input  logic [LANE_W*LANES-1:0] in_data,
    input  logic [LANES-1:0]        in_keep,
    input  logic                    in_last,
    output logic [LANE_W-1:0]       issue_word,
    output logic                    issue_keep,
    output logic                    last_lane,
    output logic                    buf_last
);
    localparam int IDX_W = clog2(LANES);
    // Buffer padded to a power of two so any index value selects a real
    // slot; padding slots never hold a kept word.
    localparam int SLOTS = 1 << IDX_W;

    logic [SLOTS-1:0][LANE_W-1:0] in_words;
    logic [SLOTS-1:0][LANE_W-1:0] buf_words;
    logic [SLOTS-1:0]             in_keeps;
    logic [SLOTS-1:0]             buf_keep;
    logic [IDX_W-1:0]             lane;
    logic [IDX_W-1:0]             lane_nxt;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i < LANES) begin : g_live
            assign in_words[i] = in_data[LANE_W*i +: LANE_W];
            assign in_keeps[i] = in_keep[i];
        end else begin : g_pad
            assign in_words[i] = '0;
            assign in_keeps[i] = 1'b0;
        end
    end

    assign last_lane  = (lane == IDX_W'(LANES - 1));
    assign lane_nxt   = lane + IDX_W'(1);
    assign issue_word = load ? in_words[0] : buf_words[lane_nxt];
    assign issue_keep = load ? in_keeps[0] : buf_keep[lane_nxt];

    always_ff @(posedge clk) begin
        if (!rst_n || discard) begin
            buf_words <= '0;
            buf_keep  <= '0;
            buf_last  <= 1'b0;
            lane      <= '0;
        end else if (load) begin
            buf_words <= in_words;
            buf_keep  <= in_keeps;
            buf_last  <= in_last;
            lane      <= '0;
        end else if (advance) begin
            lane      <= lane_nxt;
        end
    end
endmodule

// File: rtl/axis_heap_writer.sv
// AXI-Stream slave that unpacks LANES x 32-bit beats into single-word
// heap writes, one lane per cycle, starting at a programmable base.
//   axis_clk, axis_aresetn : clock, synchronous active-low reset
//   s_axis                 : stream input (axis_heap_writer_if.slave)
//   cfg_start              : arm a frame, samples cfg_base_addr (IDLE only)
//   cfg_abort              : cancel the frame from any state
//   mem_wr_en/addr/wr_data : registered heap write port
//   busy                   : in RECV or DRAIN
//   done                   : one-cycle pulse after the tlast beat drains
//   overflow               : sticky, a kept word was dropped at the heap top
//   word_count             : words written this frame, saturating at depth
module axis_heap_writer
    import gpu_axis_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int MEM_ADDR_W = 12,
    parameter int WRAP_MODE  = 0
) (
    input  logic                  axis_clk,
    input  logic                  axis_aresetn,
    axis_heap_writer_if.slave     s_axis,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [MEM_ADDR_W-1:0] cfg_base_addr,
    output logic                  mem_wr_en,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [LANE_W-1:0]     mem_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [MEM_ADDR_W:0]   word_count
);
    localparam logic [MEM_ADDR_W:0]   DEPTH   = {1'b1, {MEM_ADDR_W{1'b0}}};
    localparam logic [MEM_ADDR_W-1:0] TOP     = '1;
    localparam bit                    DO_WRAP = (WRAP_MODE != 0);

    state_t                  state, state_nxt;
    logic                    tready;
    logic                    accept;
    logic                    issue;
    logic [LANE_W-1:0]       issue_word;
    logic                    issue_keep;
    logic                    last_lane;
    logic                    buf_last;
    logic [MEM_ADDR_W-1:0]   wr_ptr;
    // Saturate mode only: the top word has been written, later words drop.
    logic                    ptr_full;

    axis_lane_unpacker #(.LANES(LANES)) u_unpack (
        .clk        (axis_clk),
        .rst_n      (axis_aresetn),
        .load       (accept),
        .advance    (state == DRAIN && !last_lane),
        .discard    (cfg_abort),
        .in_data    (s_axis.axis_tdata),
        .in_keep    (s_axis.axis_tkeep),
        .in_last    (s_axis.axis_tlast),
        .issue_word (issue_word),
        .issue_keep (issue_keep),
        .last_lane  (last_lane),
        .buf_last   (buf_last)
    );

    always_ff @(posedge axis_clk) begin
        if (!axis_aresetn) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tready    = 1'b0;
        case (state)
            IDLE:  if (cfg_start) state_nxt = RECV;
            RECV: begin
                tready = 1'b1;
                if (s_axis.axis_tvalid) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_lane) begin
                    if (buf_last) begin
                        state_nxt = DONE;
                    end else begin
                        // Overlap the next accept with the final lane for
                        // LANES cycles per beat sustained.
                        tready    = 1'b1;
                        state_nxt = s_axis.axis_tvalid ? DRAIN : RECV;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort also masks tready so no beat is handshaken and then lost.
        if (cfg_abort) begin
            state_nxt = IDLE;
            tready    = 1'b0;
        end
    end

    assign s_axis.axis_tready = tready;
    assign accept = tready && s_axis.axis_tvalid;
    // A lane is registered onto the heap port at every edge that either
    // loads a beat (its lane 0) or steps inside one (the next lane).
    assign issue  = accept || (state == DRAIN && !last_lane && !cfg_abort);
    assign busy   = (state == RECV) || (state == DRAIN);
    assign done   = (state == DONE);

    always_ff @(posedge axis_clk) begin
        if (!axis_aresetn) begin
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            wr_ptr      <= '0;
            ptr_full    <= 1'b0;
            overflow    <= 1'b0;
            word_count  <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            if (state == IDLE && cfg_start && !cfg_abort) begin
                wr_ptr     <= cfg_base_addr;
                ptr_full   <= 1'b0;
                overflow   <= 1'b0;
                word_count <= '0;
            end
            if (issue && issue_keep) begin
                if (ptr_full) begin
                    overflow <= 1'b1;
                end else begin
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= wr_ptr;
                    mem_wr_data <= issue_word;
                    wr_ptr      <= wr_ptr + MEM_ADDR_W'(1);
                    ptr_full    <= !DO_WRAP && (wr_ptr == TOP);
                    if (word_count != DEPTH)
                        word_count <= word_count + (MEM_ADDR_W+1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_heap_writer.sv
// Drives a saturating (dut 0) and a wrapping (dut 1) heap writer with the
// same stream and scores every heap write, done pulse and status word
// against a frame-level model: the n-th kept word of a frame goes to
// base+n (mod depth, or dropped past the top), lane k of a beat accepted
// at edge E appears in cycle E+k, done appears in cycle E+LANES.
module tb_axis_heap_writer;
    localparam int LANES = 2;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    typedef struct { int d; int a; logic [31:0] w; int c; } wr_t;
    typedef struct { int d; int c; } dn_t;

    logic clk = 1'b0;
    logic rstn, start, abort, tlast, tvalid;
    logic [AW-1:0]         base;
    logic [32*LANES-1:0]   tdata;
    logic [LANES-1:0]      tkeep;
    logic                  wen [2];
    logic [AW-1:0]         maddr [2];
    logic [31:0]           mdata [2];
    logic                  busy [2], done [2], ovf [2], tready [2];
    logic [AW:0]           wc [2];
    int cyc = 0;
    int vectors = 0, miscompares = 0;

    wr_t expq [$];
    dn_t donq [$];
    int  m_base [2], m_n [2], m_wr [2], m_drop_c [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_heap_writer_if #(.LANES(LANES)) ax0 ();
    axis_heap_writer_if #(.LANES(LANES)) ax1 ();
    assign ax0.axis_tdata  = tdata;  assign ax1.axis_tdata  = tdata;
    assign ax0.axis_tkeep  = tkeep;  assign ax1.axis_tkeep  = tkeep;
    assign ax0.axis_tlast  = tlast;  assign ax1.axis_tlast  = tlast;
    assign ax0.axis_tvalid = tvalid; assign ax1.axis_tvalid = tvalid;
    assign tready[0] = ax0.axis_tready;
    assign tready[1] = ax1.axis_tready;

    axis_heap_writer #(.LANES(LANES), .MEM_ADDR_W(AW), .WRAP_MODE(0)) dut_sat (
        .axis_clk(clk), .axis_aresetn(rstn), .s_axis(ax0),
        .cfg_start(start), .cfg_abort(abort), .cfg_base_addr(base),
        .mem_wr_en(wen[0]), .mem_addr(maddr[0]), .mem_wr_data(mdata[0]),
        .busy(busy[0]), .done(done[0]), .overflow(ovf[0]), .word_count(wc[0])
    );

    axis_heap_writer #(.LANES(LANES), .MEM_ADDR_W(AW), .WRAP_MODE(1)) dut_wrap (
        .axis_clk(clk), .axis_aresetn(rstn), .s_axis(ax1),
        .cfg_start(start), .cfg_abort(abort), .cfg_base_addr(base),
        .mem_wr_en(wen[1]), .mem_addr(maddr[1]), .mem_wr_data(mdata[1]),
        .busy(busy[1]), .done(done[1]), .overflow(ovf[1]), .word_count(wc[1])
    );

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_base[d] = 0; m_n[d] = 0; m_wr[d] = 0; m_drop_c[d] = -1;
        end
    endfunction

    function automatic void model_start();
        for (int d = 0; d < 2; d++) begin
            m_base[d] = int'(base); m_n[d] = 0; m_wr[d] = 0; m_drop_c[d] = -1;
        end
    endfunction

    function automatic void model_accept(input int d, input int e);
        wr_t t;
        int  lin;
        for (int k = 0; k < LANES; k++) begin
            if (tkeep[k]) begin
                lin = m_base[d] + m_n[d];
                m_n[d]++;
                if (d == 1 || lin < DEPTH) begin
                    t.d = d; t.a = lin % DEPTH; t.w = tdata[32*k +: 32]; t.c = e + k;
                    expq.push_back(t);
                    if (m_wr[d] < DEPTH) m_wr[d]++;
                end else if (m_drop_c[d] < 0) begin
                    m_drop_c[d] = e + k;
                end
            end
        end
        if (tlast) begin
            dn_t n;
            n.d = d; n.c = e + LANES;
            donq.push_back(n);
        end
    endfunction

    // Abort or reset sampled at the edge after cycle c: anything the model
    // scheduled for a later cycle never happens.
    function automatic void truncate(input int c);
        for (int i = expq.size() - 1; i >= 0; i--)
            if (expq[i].c > c) begin m_wr[expq[i].d]--; expq.delete(i); end
        for (int i = donq.size() - 1; i >= 0; i--)
            if (donq[i].c > c) donq.delete(i);
        for (int d = 0; d < 2; d++)
            if (m_drop_c[d] > c) m_drop_c[d] = -1;
    endfunction

    // Inputs are set at a falling edge; settle, model the coming rising
    // edge, then return at the next falling edge.
    task automatic step(output logic acc);
        logic a0, a1;
        #1;
        a0 = tvalid && tready[0];
        a1 = tvalid && tready[1];
        if (!rstn) begin
            truncate(cyc);
            model_reset();
        end else begin
            if (abort) truncate(cyc);
            else if (start) model_start();
            if (a0) model_accept(0, cyc + 1);
            if (a1) model_accept(1, cyc + 1);
        end
        acc = a0;
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        int idx;
        for (int d = 0; d < 2; d++) begin
            if (wen[d] === 1'b1) begin
                idx = -1;
                for (int i = 0; i < expq.size(); i++)
                    if (idx < 0 && expq[i].d == d) idx = i;
                chk("write_expected", d, 64'(idx >= 0), 64'd1);
                if (idx >= 0) begin
                    chk("write_addr",  d, 64'(maddr[d]), 64'(expq[idx].a));
                    chk("write_data",  d, 64'(mdata[d]), 64'(expq[idx].w));
                    chk("write_cycle", d, 64'(cyc),      64'(expq[idx].c));
                    expq.delete(idx);
                end
            end
            if (done[d] === 1'b1) begin
                idx = -1;
                for (int i = 0; i < donq.size(); i++)
                    if (idx < 0 && donq[i].d == d) idx = i;
                chk("done_expected", d, 64'(idx >= 0), 64'd1);
                if (idx >= 0) begin
                    chk("done_cycle", d, 64'(cyc), 64'(donq[idx].c));
                    donq.delete(idx);
                end
            end
        end
    end

    task automatic start_frame(input logic [AW-1:0] b);
        logic acc;
        base = b; start = 1'b1;
        step(acc);
        start = 1'b0;
        for (int d = 0; d < 2; d++) chk("tready_armed", d, 64'(tready[d]), 64'd1);
    endtask

    task automatic send_beat(input logic [63:0] dat, input logic [1:0] k, input logic l, output int acc_cyc);
        logic acc;
        int   n;
        tvalid = 1'b1; tdata = dat; tkeep = k; tlast = l;
        acc = 1'b0; n = 0; acc_cyc = -1;
        while (!acc && n < 50) begin
            acc_cyc = cyc + 1;
            step(acc);
            n++;
        end
        chk("beat_accept", 0, 64'(acc), 64'd1);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        tvalid = 1'b0; n = 0;
        while ((expq.size() != 0 || donq.size() != 0) && n < 200) begin
            step(acc);
            n++;
        end
        chk("drain_bound", 0, 64'(n < 200), 64'd1);
        step(acc);
    endtask

    task automatic chk_status();
        for (int d = 0; d < 2; d++) begin
            chk("word_count", d, 64'(wc[d]),  64'(m_wr[d]));
            chk("overflow",   d, 64'(ovf[d]), 64'(m_drop_c[d] >= 0));
            chk("busy_idle",  d, 64'(busy[d]), 64'd0);
        end
    endtask

    task automatic chk_reset_state();
        for (int d = 0; d < 2; d++) begin
            chk("rst_tready", d, 64'(tready[d]), 64'd0);
            chk("rst_wr_en",  d, 64'(wen[d]),    64'd0);
            chk("rst_addr",   d, 64'(maddr[d]),  64'd0);
            chk("rst_data",   d, 64'(mdata[d]),  64'd0);
            chk("rst_busy",   d, 64'(busy[d]),   64'd0);
            chk("rst_done",   d, 64'(done[d]),   64'd0);
            chk("rst_ovf",    d, 64'(ovf[d]),    64'd0);
            chk("rst_wc",     d, 64'(wc[d]),     64'd0);
        end
    endtask

    initial begin
        logic acc;
        int   e0, e1, nb, gaps;
        logic [63:0] rd;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; base = '0;
        tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
        model_reset();
        @(negedge clk);
        step(acc);
        chk_reset_state();
        rstn = 1'b1;
        step(acc);

        // Two full beats, back to back
        start_frame(9'h010);
        send_beat(64'h22222222_11111111, 2'b11, 1'b0, e0);
        send_beat(64'h44444444_33333333, 2'b11, 1'b1, e1);
        chk("beat_spacing", 0, 64'(e1 - e0), 64'(LANES));
        drain();
        chk_status();
        chk("t1_wc", 0, 64'(wc[0]), 64'd4);

        // Keep gap: lane 0 skipped
        start_frame(9'h020);
        send_beat(64'hBBBBBBBB_AAAAAAAA, 2'b10, 1'b1, e0);
        tvalid = 1'b0;
        chk("gap_no_write", 0, 64'(wen[0]), 64'd0);
        drain();
        chk_status();
        chk("t2_wc", 0, 64'(wc[0]), 64'd1);

        // Heap top: saturate drops, wrap rolls over to 0
        start_frame(9'h1FE);
        send_beat(64'h0000000B_0000000A, 2'b11, 1'b0, e0);
        send_beat(64'h0000000D_0000000C, 2'b11, 1'b1, e1);
        drain();
        chk_status();
        chk("sat_wc",   0, 64'(wc[0]),  64'd2);
        chk("sat_ovf",  0, 64'(ovf[0]), 64'd1);
        chk("wrap_wc",  1, 64'(wc[1]),  64'd4);
        chk("wrap_ovf", 1, 64'(ovf[1]), 64'd0);

        // Abort after first beat of a longer frame, stream keeps offering
        start_frame(9'h040);
        send_beat(64'h66666666_55555555, 2'b11, 1'b0, e0);
        tdata = 64'h88888888_77777777; abort = 1'b1;
        step(acc);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < 2; d++) begin
                chk("abort_tready", d, 64'(tready[d]), 64'd0);
                chk("abort_busy",   d, 64'(busy[d]),   64'd0);
            end
            step(acc);
        end
        drain();
        chk_status();
        chk("abort_wc_hold", 0, 64'(wc[0]), 64'd1);
        start_frame(9'h100);
        send_beat(64'hA1A1A1A1_F0F0F0F0, 2'b11, 1'b1, e0);
        drain();
        chk_status();

        // Random frames with random keeps and tvalid gaps
        for (int f = 0; f < 5; f++) begin
            start_frame(AW'($urandom_range(0, 9'h180)));
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                gaps = $urandom_range(0, 2);
                tvalid = 1'b0;
                for (int g = 0; g < gaps; g++) step(acc);
                rd = {$urandom, $urandom};
                send_beat(rd, 2'($urandom_range(0, 3)), b == nb - 1, e0);
            end
            drain();
            chk_status();
        end

        // Reset while draining a beat
        start_frame(9'h0C0);
        send_beat(64'hCAFECAFE_BEEFBEEF, 2'b11, 1'b0, e0);
        tvalid = 1'b0; rstn = 1'b0;
        step(acc);
        chk_reset_state();
        rstn = 1'b1;
        step(acc);

        // Start and abort together: abort wins
        start = 1'b1; abort = 1'b1; base = 9'h055;
        step(acc);
        start = 1'b0; abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("sa_tready", d, 64'(tready[d]), 64'd0);
            chk("sa_busy",   d, 64'(busy[d]),   64'd0);
        end

        // Clean frame after reset
        start_frame(9'h1F0);
        send_beat(64'h12345678_9ABCDEF0, 2'b01, 1'b1, e0);
        drain();
        chk_status();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axis_heap_writer.md
Name: axis_heap_writer

Overview:
Parametrised AXI-Stream slave that unpacks a wide stream into 32-bit word writes on the GPU heap/data memory write port.
Generalises the fixed 32-bit AXI-Stream ingest path to N 32-bit lanes, with per-lane keep, a programmable base address, wrap or saturate addressing, and frame completion and overflow status.
Sits between the host DMA stream and the heap BRAM port. It is armed from the IO-register block in the same clock domain.

Parameters:
LANES, 2, number of 32-bit lanes per beat; TDATA width = 32*LANES; legal range 1..8
MEM_ADDR_W, 12, heap word-address width; heap depth = 2**MEM_ADDR_W words
WRAP_MODE, 0, 1 = address wraps modulo depth; 0 = saturate at top, drop excess words, flag overflow

Ports:
axis_clk  in  1  sole clock
axis_aresetn  in  1  synchronous active-low reset
axis_tdata  in  32*LANES  stream data; lane i = bits [32i+31:32i], lane 0 written first
axis_tkeep  in  LANES  one bit per 32-bit lane; 0 = skip lane
axis_tlast  in  1  last beat of frame
axis_tvalid  in  1  beat valid
axis_tready  out  1  beat accept
cfg_start  in  1  one-cycle pulse; arms a frame
cfg_abort  in  1  one-cycle pulse; cancels the current frame
cfg_base_addr  in  MEM_ADDR_W  first heap word address, sampled on cfg_start
mem_wr_en  out  1  heap write strobe
mem_addr  out  MEM_ADDR_W  heap word address
mem_wr_data  out  32  heap write data
busy  out  1  high in RECV/DRAIN
done  out  1  one-cycle pulse at frame end
overflow  out  1  sticky; set when a word is dropped; cleared by cfg_start
word_count  out  MEM_ADDR_W+1  words written this frame; held after done until next cfg_start

Behaviour:
- Reset (axis_aresetn=0 at a rising edge): state IDLE. All outputs 0: tready, mem_wr_en, mem_addr, mem_wr_data, busy, done, overflow, word_count. Lane buffer cleared.
- States and transitions:
  - IDLE:
    - tready=0.
    - cfg_start loads wr_ptr=cfg_base_addr, clears word_count and overflow, then goes to RECV.
  - RECV:
    - tready=1.
    - A beat is accepted when tvalid&&tready. It latches tdata/tkeep/tlast into the lane buffer, sets lane=0 and goes to DRAIN.
  - DRAIN:
    - One lane is processed per cycle.
    - If keep[lane]=1: mem_wr_en=1, mem_addr=wr_ptr, mem_wr_data=lane word; then wr_ptr+1 and word_count+1.
    - If keep[lane]=0: mem_wr_en=0; the cycle is still consumed and the pointer does not advance.
  - On the final lane of a beat:
    - Buffered tlast=1: go to DONE.
    - Otherwise tready=1 in that same cycle. An accepted beat reloads the buffer and stays in DRAIN, giving LANES cycles/beat sustained. With no accept, go to RECV.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Output timing: mem_* outputs are registered. A beat accepted at edge N has its lane 0 on mem_* during cycle N+1 and lane k during cycle N+1+k.
- Boundary, WRAP_MODE=1: wr_ptr wraps from 2**MEM_ADDR_W-1 to 0; no overflow.
- Boundary, WRAP_MODE=0:
  - After writing address 2**MEM_ADDR_W-1, further kept words get mem_wr_en=0 and word_count does not advance.
  - overflow is set on the first dropped word.
  - The stream is still consumed to tlast; done still pulses.
- word_count saturates at 2**MEM_ADDR_W.
- cfg_abort:
  - From any state, next cycle is IDLE with tready=0.
  - Buffer discarded; no done pulse.
  - word_count and overflow hold.
  - A write in flight on the abort cycle completes; none follow.
- Simultaneous events:
  - cfg_abort and cfg_start in the same cycle: abort wins.
  - cfg_start outside IDLE is ignored.
- tkeep all zero: the beat is consumed, no writes, LANES cycles.
- Reset mid-frame behaves as full reset; the partial frame is abandoned.
- Throughput: LANES=1 gives 1 beat/cycle sustained.

Decomposition:
- Shared package gpu_axis_pkg:
  - state enum {IDLE, RECV, DRAIN, DONE}
  - LANE_W=32 constant
  - function clog2 for the lane index width
- One natural sub-module: axis_lane_unpacker. It holds the lane buffer and index and emits lane word/keep/last_lane.
- The parent holds the FSM, address pointer, counters and status.

Test Plan:
1. LANES=2, base=0x010, beats {tdata=0x22222222_11111111, keep=11} then {0x44444444_33333333, keep=11, tlast} -> writes 0x010=11111111, 0x011=22222222, 0x012=33333333, 0x013=44444444; one done; word_count=4.
2. Keep gaps: beat keep=10, tdata=0xBBBBBBBB_AAAAAAAA, tlast, base=0x020 -> single write 0x020=BBBBBBBB; cycle 1 has mem_wr_en=0; word_count=1.
3. WRAP_MODE=0, MEM_ADDR_W=4, base=0xE, 2 beats keep=11 with tlast -> writes at 0xE and 0xF only; overflow=1; word_count=2; done pulses after the 4th lane cycle.
4. WRAP_MODE=1, same stimulus -> writes 0xE, 0xF, 0x0, 0x1; overflow=0; word_count=4.
5. Abort after the first beat of a 3-beat frame, then tvalid held high -> tready=0 from the next cycle; no done; the following cfg_start with base=0x100 writes from 0x100.
6. Backpressure and reset: tvalid toggling 1/0 with random gaps, then axis_aresetn=0 mid-DRAIN -> no beat lost or duplicated before reset; the next cycle after reset has all outputs 0 and state IDLE.
